// File: rtl/hack_mem_responder.sv
// Hack CPU memory responder: data RAM, screen shadow with a framebuffer write FIFO,
// keyboard register and sticky error flags.
module hack_mem_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_WORDS  = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memAddress,
    input  logic [15:0] memOut,
    input  logic        writeM,
    output logic [15:0] memIn,
    output logic        stall,
    output logic [12:0] fbAddr,
    output logic [15:0] fbData,
    output logic        fbValid,
    input  logic        fbReady,
    input  logic [15:0] kbdCode,
    input  logic        kbdStrobe,
    output logic        errAddr,
    output logic        overflow
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [15:0]      r_ram      [RAM_WORDS];
    logic [15:0]      r_shadow   [8192];
    logic [12:0]      r_fifoAddr [FIFO_DEPTH];
    logic [15:0]      r_fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_kbd;
    logic             r_errAddr;
    logic             r_overflow;

    logic        w_known;
    logic        w_isRam;
    logic        w_isScreen;
    logic        w_isKbd;
    logic        w_isUnmapped;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic [12:0] w_scrOffset;

    // An address with any X/Z bit is treated as no access at all.
    assign w_known      = !$isunknown(memAddress);
    assign w_isRam      = w_known && (memAddress < 16'h4000);
    assign w_isScreen   = w_known && (memAddress[15:13] == 3'b010);
    assign w_isKbd      = w_known && (memAddress == 16'h6000);
    assign w_isUnmapped = w_known && (memAddress > 16'h6000);
    assign w_scrOffset  = memAddress[12:0];

    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = (r_count != '0) && fbReady;
    assign w_push   = w_isScreen && writeM;
    assign w_accept = w_push && (!w_full || w_pop);

    // Storage arrays are deliberately not reset.
    always_ff @(posedge clk) begin
        if (writeM && w_isRam) begin
            r_ram[memAddress[RAM_AW-1:0]] <= memOut;
        end
        if (w_push) begin
            r_shadow[w_scrOffset] <= memOut;
        end
        if (w_accept) begin
            r_fifoAddr[r_wrPtr] <= w_scrOffset;
            r_fifoData[r_wrPtr] <= memOut;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_kbd      <= 16'h0000;
            r_errAddr  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_isUnmapped) begin
                r_errAddr <= 1'b1;
            end
            // A keyboard strobe beats a simultaneous CPU clear.
            if (kbdStrobe) begin
                r_kbd <= kbdCode;
            end else if (writeM && w_isKbd) begin
                r_kbd <= 16'h0000;
            end
        end
    end

    always_comb begin
        memIn = 16'h0000;
        if (w_isRam) begin
            memIn = r_ram[memAddress[RAM_AW-1:0]];
        end else if (w_isScreen) begin
            memIn = r_shadow[w_scrOffset];
        end else if (w_isKbd) begin
            memIn = r_kbd;
        end
    end

    assign stall    = w_full;
    assign fbValid  = (r_count != '0);
    assign fbAddr   = r_fifoAddr[r_rdPtr];
    assign fbData   = r_fifoData[r_rdPtr];
    assign errAddr  = r_errAddr;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Self-checking bench for hack_mem_responder: directed scenarios plus randomized
// traffic compared against a queue/array reference model.
`timescale 1ns/1ps
module tb_hack_mem_responder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memAddress;
    logic [15:0] memOut;
    logic        writeM;
    logic [15:0] memIn;
    logic        stall;
    logic [12:0] fbAddr;
    logic [15:0] fbData;
    logic        fbValid;
    logic        fbReady;
    logic [15:0] kbdCode;
    logic        kbdStrobe;
    logic        errAddr;
    logic        overflow;

    always #10 clk = ~clk;

    hack_mem_responder #(
        .FIFO_DEPTH(DEPTH),
        .RAM_WORDS (16384)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memAddress(memAddress),
        .memOut    (memOut),
        .writeM    (writeM),
        .memIn     (memIn),
        .stall     (stall),
        .fbAddr    (fbAddr),
        .fbData    (fbData),
        .fbValid   (fbValid),
        .fbReady   (fbReady),
        .kbdCode   (kbdCode),
        .kbdStrobe (kbdStrobe),
        .errAddr   (errAddr),
        .overflow  (overflow)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic [15:0] mRam    [0:16383];
    logic [15:0] mShadow [0:8191];
    logic [28:0] mQueue  [$];
    logic [15:0] mKbd;
    logic        mErr;
    logic        mOvf;
    bit          memChecked = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] expRead(input logic [15:0] a);
        if (a < 16'h4000) return mRam[a[13:0]];
        if (a < 16'h6000) return mShadow[a[12:0]];
        if (a == 16'h6000) return mKbd;
        return 16'h0000;
    endfunction

    task automatic compareModel();
        if (memChecked) begin
            checkOutput("memIn", 32'(memIn), 32'(expRead(memAddress)));
        end
        checkOutput("fbValid", 32'(fbValid), 32'(mQueue.size() != 0));
        checkOutput("stall", 32'(stall), 32'(mQueue.size() == DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("errAddr", 32'(errAddr), 32'(mErr));
        if (mQueue.size() != 0) begin
            checkOutput("fbAddr", 32'(fbAddr), 32'(mQueue[0][28:16]));
            checkOutput("fbData", 32'(fbData), 32'(mQueue[0][15:0]));
        end
    endtask

    // Applies the memory-map rules for one rising edge using the inputs held across it.
    task automatic updateModel();
        logic [15:0] a;
        bit popNow;
        bit roomNow;
        bit isScreen;
        a        = memAddress;
        popNow   = (mQueue.size() != 0) && (fbReady == 1'b1);
        roomNow  = (mQueue.size() < DEPTH) || popNow;
        isScreen = (a >= 16'h4000) && (a < 16'h6000);
        if (a > 16'h6000) mErr = 1'b1;
        if (writeM && a < 16'h4000) mRam[a[13:0]] = memOut;
        if (writeM && isScreen) mShadow[a[12:0]] = memOut;
        if (popNow) void'(mQueue.pop_front());
        if (writeM && isScreen) begin
            if (roomNow) mQueue.push_back({a[12:0], memOut});
            else mOvf = 1'b1;
        end
        if (kbdStrobe) mKbd = kbdCode;
        else if (writeM && a == 16'h6000) mKbd = 16'h0000;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w,
                                 input logic rdy, input logic s, input logic [15:0] code);
        @(negedge clk);
        memAddress = a;
        memOut     = d;
        writeM     = w;
        fbReady    = rdy;
        kbdStrobe  = s;
        kbdCode    = code;
        #1;
        compareModel();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic peekRead(input string tag, input logic [15:0] a, input logic [15:0] exp);
        memAddress = a;
        #1;
        checkOutput(tag, 32'(memIn), 32'(exp));
    endtask

    task automatic pulseReset(input bit doCheck);
        @(negedge clk);
        #2;
        writeM     = 1'b0;
        kbdStrobe  = 1'b0;
        fbReady    = 1'b0;
        memAddress = 16'h0010;
        reset      = 1'b0;
        #1;
        mQueue.delete();
        mKbd = 16'h0000;
        mErr = 1'b0;
        mOvf = 1'b0;
        if (doCheck) begin
            checkOutput("rstFbValid", 32'(fbValid), 32'd0);
            checkOutput("rstStall", 32'(stall), 32'd0);
            checkOutput("rstOverflow", 32'(overflow), 32'd0);
            checkOutput("rstErrAddr", 32'(errAddr), 32'd0);
            checkOutput("rstRamKept", 32'(memIn), 32'h1234);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [15:0] drainExp [4];
        reset      = 1'b0;
        memAddress = 16'h6000;
        memOut     = 16'h0000;
        writeM     = 1'b0;
        fbReady    = 1'b0;
        kbdCode    = 16'h0000;
        kbdStrobe  = 1'b0;
        mKbd       = 16'h0000;
        mErr       = 1'b0;
        mOvf       = 1'b0;
        foreach (mRam[i]) mRam[i] = 16'h0000;
        foreach (mShadow[i]) mShadow[i] = 16'h0000;

        @(posedge clk);
        #1;
        checkOutput("initFbValid", 32'(fbValid), 32'd0);
        checkOutput("initStall", 32'(stall), 32'd0);
        checkOutput("initOverflow", 32'(overflow), 32'd0);
        checkOutput("initErrAddr", 32'(errAddr), 32'd0);
        checkOutput("initKbd", 32'(memIn), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Zero the RAM and screen windows that later traffic uses.
        for (int i = 0; i < 64; i++) applyStimulus(16'(i), 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 64; i++) applyStimulus(16'h4000 + 16'(i), 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        memChecked = 1'b1;

        $display("[TB] RAM write/read");
        applyStimulus(16'h0010, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000);
        peekRead("ramRead", 16'h0010, 16'h1234);
        peekRead("ramNeighbour", 16'h0011, 16'h0000);

        $display("[TB] FIFO fill and drain");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h4000 + 16'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0000);
            if (i == 3) checkOutput("stallAt4", 32'(stall), 32'd1);
        end
        checkOutput("overflowSet", 32'(overflow), 32'd1);
        peekRead("shadowDropped", 16'h4004, 16'hA004);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drainAddr", 32'(fbAddr), 32'(i));
            applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        end
        checkOutput("drainEmpty", 32'(fbValid), 32'd0);

        pulseReset(1'b0);

        $display("[TB] full push with pop");
        for (int i = 0; i < 4; i++) applyStimulus(16'h4020 + 16'(i), 16'hC000 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(16'h4010, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("pushPopOvf", 32'(overflow), 32'd0);
        checkOutput("pushPopStall", 32'(stall), 32'd1);
        drainExp[0] = 16'hC001;
        drainExp[1] = 16'hC002;
        drainExp[2] = 16'hC003;
        drainExp[3] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            checkOutput("pushPopOrder", 32'(fbData), 32'(drainExp[i]));
            applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        end

        $display("[TB] keyboard");
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0041);
        peekRead("kbdLoad", 16'h6000, 16'h0041);
        applyStimulus(16'h6000, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000);
        peekRead("kbdClear", 16'h6000, 16'h0000);
        applyStimulus(16'h6000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0042);
        peekRead("kbdCollide", 16'h6000, 16'h0042);

        $display("[TB] unmapped access");
        applyStimulus(16'h7000, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("unmapErr", 32'(errAddr), 32'd1);
        checkOutput("unmapNoPush", 32'(fbValid), 32'd0);
        peekRead("unmapRead", 16'h7000, 16'h0000);
        peekRead("unmapRamSafe", 16'h0010, 16'h1234);

        $display("[TB] reset with entries queued");
        for (int i = 0; i < 5; i++) applyStimulus(16'h4030 + 16'(i), 16'hD000 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        pulseReset(1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            logic [15:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 4) a = 16'($urandom_range(0, 63));
            else if (sel < 7) a = 16'h4000 + 16'($urandom_range(0, 63));
            else if (sel < 9) a = 16'h6000;
            else a = 16'($urandom_range(32'h6001, 32'hFFFF));
            applyStimulus(a, 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                          16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hack_mem_responder.md
HACK_MEM_RESPONDER -- requirements
Module: hack_mem_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4; framebuffer write FIFO entries, power of two, 2..16.
REQ-002 Parameter RAM_WORDS, default 16384; data RAM size at 0x0000-0x3FFF.
REQ-003 clk  in  1  rising-edge clock; only clock.
REQ-004 reset  in  1  asynchronous, active-low: asserted when 0, deasserted when 1.
REQ-005 memAddress  in  16  CPU access address; any bit X/Z = no access.
REQ-006 memOut  in  16  CPU write data.
REQ-007 writeM  in  1  CPU write strobe, sampled on rising clk.
REQ-008 memIn  out  16  read data to CPU, combinational from memAddress.
REQ-009 stall  out  1  FIFO full; CPU must hold its screen write.
REQ-010 fbAddr  out  13  screen word offset of the FIFO head.
REQ-011 fbData  out  16  data of the FIFO head.
REQ-012 fbValid  out  1  FIFO not empty.
REQ-013 fbReady  in  1  framebuffer accepts the head entry.
REQ-014 kbdCode  in  16  keyboard scan code.
REQ-015 kbdStrobe  in  1  new key code present, sampled on rising clk.
REQ-016 errAddr  out  1  sticky: an access hit an unmapped address (>0x6000).
REQ-017 overflow  out  1  sticky: a screen write was dropped.

Function
REQ-018 Address map:
  - 0x0000-0x3FFF: RAM.
  - 0x4000-0x5FFF: screen.
  - 0x6000: keyboard.
  - 0x6001-0xFFFF: unmapped.
REQ-019 RAM write: writeM=1 in the RAM range stores memOut at memAddress on the same edge.
REQ-020 RAM read: memIn = RAM[memAddress] with zero latency; a write is visible the cycle after its edge.
REQ-021 Screen write: writeM=1 in the screen range updates a screen shadow word and pushes {memAddress-0x4000, memOut} into the FIFO on the same edge.
REQ-022 Screen read: memIn returns the shadow word, including writes not yet drained to the framebuffer.
REQ-023 Keyboard read: memIn at 0x6000 = keyboard register.
REQ-024 Keyboard load: kbdStrobe=1 loads kbdCode into the register at the edge.
REQ-025 Keyboard clear: a CPU write to 0x6000 clears the register to 0, whatever the data.
REQ-026 Keyboard collision: kbdStrobe=1 in the same cycle as a CPU write to 0x6000 loads kbdCode (strobe wins).
REQ-027 Unmapped access: read returns 0x0000; write ignored; either sets errAddr.
REQ-028 No access (X/Z address or writeM=0 with no read use): memIn returns 0x0000; no state change.
REQ-029 FIFO organisation: circular, read pointer and write pointer wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
REQ-030 FIFO pop: occurs on an edge where fbValid=1 and fbReady=1.
REQ-031 FIFO output: fbAddr/fbData show the head entry and are stable while fbValid=1 and fbReady=0.
REQ-032 stall = (count == FIFO_DEPTH), registered from count.
REQ-033 Push when count < FIFO_DEPTH: accepted.
REQ-034 Push when full with a pop on the same edge: accepted; count unchanged; pointers both advance.
REQ-035 Push when full without a pop: dropped; overflow set; shadow still updated.
REQ-036 Push and pop together when not full: count unchanged.
REQ-037 Empty FIFO: fbValid=0; fbReady ignored; no pop.
REQ-038 Entries drain in push order, one per cycle at most.

Reset
REQ-039 reset=0 immediately, without a clock, clears:
  - FIFO pointers and count; fbValid=0; stall=0;
  - keyboard register = 0;
  - errAddr=0; overflow=0.
REQ-040 RAM and screen shadow contents are not cleared by reset.
REQ-041 Reset mid-drain discards all queued entries; fbAddr/fbData are don't-care while fbValid=0.
REQ-042 First push is accepted on the first rising clk after reset returns to 1.

Verification
REQ-043 RAM: write 0x1234 to 0x0010 -> next cycle memIn=0x1234 at 0x0010; memIn=0x0000 at 0x0011 after RAM preload of zeros.
REQ-044 FIFO fill/drain, FIFO_DEPTH=4, fbReady=0:
  - Stimulus: 5 screen writes to 0x4000..0x4004, data 0xA000..0xA004.
  - Response: stall=1 after the 4th; 5th dropped; overflow=1; memIn at 0x4004 = 0xA004.
  - Then fbReady=1: fbAddr 0,1,2,3 on consecutive cycles, then fbValid=0.
REQ-045 Full with simultaneous push and pop:
  - Stimulus: FIFO full, fbReady=1, push 0x4010 with data 0xBEEF.
  - Response: accepted; overflow stays 0; 0xBEEF appears as the 4th drained entry.
REQ-046 Keyboard:
  - kbdStrobe with 0x0041 -> memIn at 0x6000 = 0x0041.
  - CPU write to 0x6000 -> 0x0000.
  - Same-cycle strobe 0x0042 and CPU write -> 0x0042.
REQ-047 Unmapped: write to 0x7000 -> errAddr=1, no RAM/FIFO change; read of 0x7000 -> memIn=0x0000.
REQ-048 Reset: assert reset=0 between edges with 3 entries queued -> fbValid, stall, overflow, errAddr = 0 immediately; RAM word 0x0010 retains 0x1234.
